muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / 32/32 divide unit with HI/LO result registers.
// Multiply uses shift-add over 32 cycles; divide uses restoring shift-subtract.
// Signed operations run on magnitudes, and the sign is restored in a single FIX cycle.
module muldiv_unit #(
    parameter logic [31:0] DIV0_LO = 32'hFFFFFFFF
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q;
    logic        [4:0]  cnt_q;
    logic               busy_q;
    logic               done_q;
    logic        [31:0] hi_q;
    logic        [31:0] lo_q;

    // Operation context, captured on the accepted start edge
    logic               is_div_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic               div0_q;
    logic        [31:0] rs_raw_q;
    logic        [31:0] b_q;
    // Multiply: {partial product, remaining multiplier bits}; divide: {remainder, quotient}
    logic        [63:0] work_q;
    logic        [63:0] work_d;

    logic               rs_neg;
    logic               rt_neg;
    logic        [31:0] rs_mag;
    logic        [31:0] rt_mag;
    logic        [32:0] mul_sum;
    logic        [32:0] div_shift;
    logic        [33:0] div_trial;
    logic        [63:0] prod_fix;
    logic        [31:0] quo_fix;
    logic        [31:0] rem_fix;

    // Operand magnitudes; only the signed ops (op[0] = 1) treat bit 31 as a sign
    always_comb begin
        rs_neg = op[0] & rs_data[31];
        rt_neg = op[0] & rt_data[31];
        rs_mag = rs_neg ? (32'd0 - rs_data) : rs_data;
        rt_mag = rt_neg ? (32'd0 - rt_data) : rt_data;
    end

    // One iteration of shift-add or restoring division, plus the final sign correction
    always_comb begin
        mul_sum   = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, b_q} : 33'd0);
        div_shift = {work_q[63:32], work_q[31]};
        div_trial = {1'b0, div_shift} - {2'b00, b_q};
        work_d    = {mul_sum, work_q[31:1]};
        if (is_div_q) begin
            if (div_trial[33]) begin
                work_d = {div_shift[31:0], work_q[30:0], 1'b0};
            end else begin
                work_d = {div_trial[31:0], work_q[30:0], 1'b1};
            end
        end
        prod_fix = neg_res_q ? (64'd0 - work_q) : work_q;
        quo_fix  = neg_res_q ? (32'd0 - work_q[31:0]) : work_q[31:0];
        rem_fix  = neg_rem_q ? (32'd0 - work_q[63:32]) : work_q[63:32];
    end

    // Datapath: latch operands on an accepted start, iterate while in CALC
    always_ff @(posedge CLK) begin
        if (state_q == IDLE && start) begin
            is_div_q  <= op[1];
            neg_res_q <= rs_neg ^ rt_neg;
            neg_rem_q <= rs_neg;
            div0_q    <= op[1] && (rt_data == 32'd0);
            rs_raw_q  <= rs_data;
            if (op[1]) begin
                work_q <= {32'd0, rs_mag};
                b_q    <= rt_mag;
            end else begin
                work_q <= {32'd0, rt_mag};
                b_q    <= rs_mag;
            end
        end else if (state_q == CALC) begin
            work_q <= work_d;
        end
    end

    // Control FSM with registered busy/done and the architectural HI/LO registers
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q  <= 5'd0;
                        busy_q <= 1'b1;
                        // A zero divisor needs no iterations
                        state_q <= (op[1] && (rt_data == 32'd0)) ? FIX : CALC;
                    end else begin
                        if (mthi) hi_q <= rs_data;
                        if (mtlo) lo_q <= rs_data;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= FIX;
                end
                FIX: begin
                    if (div0_q) begin
                        lo_q <= DIV0_LO;
                        hi_q <= rs_raw_q;
                    end else if (is_div_q) begin
                        lo_q <= quo_fix;
                        hi_q <= rem_fix;
                    end else begin
                        lo_q <= prod_fix[31:0];
                        hi_q <= prod_fix[63:32];
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
